// File: rtl/intc_wb8.sv
// Eight-input Wishbone interrupt controller: synchronises request lines, latches
// rising edges into PENDING, masks them with ENABLE and drives one registered IRQ.
module intc_wb8 #(
  parameter int NUM_IRQ = 4
) (
  input  logic               I_wb_clk,
  input  logic               I_reset,
  input  logic [1:0]         I_wb_adr,
  input  logic [7:0]         I_wb_dat,
  input  logic               I_wb_stb,
  input  logic               I_wb_we,
  output logic [7:0]         O_wb_dat,
  output logic               O_wb_ack,
  input  logic [NUM_IRQ-1:0] I_irq,
  output logic               O_interrupt
);

  // Bits at and above NUM_IRQ are held at zero so they read 0 and ignore writes.
  localparam logic [7:0] IRQ_MASK = 8'((16'd1 << NUM_IRQ) - 16'd1);

  logic [NUM_IRQ-1:0] s1, s2, prev;
  logic [7:0]         edge8, set8, clr8;
  logic [7:0]         pending, pending_nxt, enable, active;
  logic [7:0]         rd_data;
  logic [2:0]         vec_idx;
  logic               wr;

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= I_irq;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_comb begin
    edge8              = '0;
    edge8[NUM_IRQ-1:0] = s2 & ~prev;
  end

  // Bus handshake: a transfer is any cycle with I_wb_stb high; O_wb_ack follows
  // stb one cycle later, and a write lands on every edge that samples stb & we.
  assign wr   = I_wb_stb & I_wb_we;
  assign set8 = (wr && I_wb_adr == 2'd2) ? (I_wb_dat & IRQ_MASK) : 8'h00;
  assign clr8 = (wr && I_wb_adr == 2'd0) ? (I_wb_dat & IRQ_MASK) : 8'h00;

  // Sets (hardware edge or software trigger) win over a same-cycle clear.
  assign pending_nxt = (edge8 | set8 | (pending & ~clr8)) & IRQ_MASK;
  assign active      = pending & enable;

  always_comb begin
    vec_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (I_wb_adr)
      2'd0: rd_data = pending;
      2'd1: rd_data = enable;
      2'd2: rd_data = active;
      2'd3: rd_data = (active != 8'h00) ? {5'b0, vec_idx} : 8'h80;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      pending     <= '0;
      enable      <= '0;
      O_interrupt <= 1'b0;
      O_wb_ack    <= 1'b0;
      O_wb_dat    <= '0;
    end else begin
      pending     <= pending_nxt;
      if (wr && I_wb_adr == 2'd1) enable <= I_wb_dat & IRQ_MASK;
      O_interrupt <= |active;
      O_wb_ack    <= I_wb_stb;
      if (I_wb_stb) O_wb_dat <= rd_data;
    end
  end

endmodule

// File: doc/intc_wb8.md
# intc_wb8

Eight-bit Wishbone interrupt controller between the SPU32 CPU's single `INTERRUPT_I` line and the interrupt-producing peripherals (timer, buttons, GPIO, UART). It replaces the direct `timer_interrupt` wire. It synchronises up to eight asynchronous request lines and latches their rising edges into a pending register. It gates the pending bits with a software enable mask and drives one registered interrupt output. In the top-level arbiter it decodes at 0xFFFFFFD0–0xFFFFFFD3.

## Interface
- `NUM_IRQ`, default 4: number of request inputs, legal range 1..8.
- `I_wb_clk` in 1: the single clock; all state is on its rising edge.
- `I_reset` in 1: reset, asynchronous and active-high.
- `I_wb_adr` in 2: register select, from `cpu_adr[1:0]`.
- `I_wb_dat` in 8: write data.
- `I_wb_stb` in 1: strobe; the arbiter holds it until ack.
- `I_wb_we` in 1: write enable.
- `O_wb_dat` out 8: read data, registered.
- `O_wb_ack` out 1: acknowledge, registered.
- `I_irq` in `NUM_IRQ`: request lines, asynchronous, active-high. A rising edge is a request.
- `O_interrupt` out 1: registered; goes to CPU `INTERRUPT_I`.

## Operation
- **Input synchronisation**
  - Each `I_irq[i]` passes through two flops (`s1`, then `s2`).
  - A third flop `prev` holds the previous `s2`.
  - Edge detected when `s2 & ~prev`.
- **Register map** (bits at and above `NUM_IRQ` read 0; writes to them are ignored):
  - 0 `PENDING`: read returns latched edges. Write: each 1 bit clears that pending bit (write-1-to-clear).
  - 1 `ENABLE`: read/write mask.
  - 2 `ACTIVE`: read returns `PENDING & ENABLE`. Write: each 1 bit sets that pending bit (software trigger).
  - 3 `VECTOR`: read-only.
    - If `ACTIVE` is nonzero: {5'b0, index of the lowest set `ACTIVE` bit}.
    - If `ACTIVE` is zero: 8'h80.
    - Writes are ignored.
- **Pending update priority**, per bit per cycle, highest first:
  - hardware edge sets the bit;
  - software set (write to 2) sets the bit;
  - software clear (write to 0) clears the bit.
  - An edge arriving in the same cycle as a clear of that bit leaves the bit set; the request is never lost.
- **Interrupt output**: `O_interrupt <= |(PENDING & ENABLE)`, evaluated on the register values before the current edge.
- **Masking**: disabling a bit in `ENABLE` does not clear its pending bit. Re-enabling it raises `O_interrupt` again.
- **Reset** clears `s1`, `s2`, `prev`, `PENDING`, `ENABLE`, `O_interrupt`, `O_wb_ack` and `O_wb_dat` to 0.
  - An `I_irq` line already high when reset releases is therefore latched as an edge. This is intended.
  - Reset asserted mid-transfer drops the transfer; no ack is issued.

## Timing
- **Bus access**
  - `O_wb_ack <= I_wb_stb` every cycle, so ack is high the cycle after the first sampled strobe.
  - Read data is registered in that same edge.
  - Writes take effect at every edge where `I_wb_stb & I_wb_we`. A write held for two cycles repeats, which is harmless because all writes are idempotent.
- **Request latency** (input rises before edge k):
  - `s1 = 1` after edge k;
  - `s2 = 1` after k+1;
  - `PENDING` bit set at k+2;
  - `O_interrupt` high after k+3, if enabled.
- **Pulse width**: `I_irq` pulses shorter than one clock may be missed. Sources must hold a request for at least 2 cycles.
- **Clear latency**:
  - a `PENDING` clear written at edge w clears the bit at w;
  - `O_interrupt` falls after w+1 if no other active bit remains.
- **Enable latency**: a write to `ENABLE` at edge w, with the bit pending, raises `O_interrupt` after w+1.
- **Sustained input**: a level held high produces exactly one edge. After it is cleared it does not re-pend until the line falls and rises again.

## Test plan
- **Reset state**: hold `I_reset`, release, read all 4 registers -> 00, 00, 00, 80. `O_interrupt` = 0. `O_wb_ack` pulses one cycle after each strobe.
- **Single request**: `ENABLE` = 0x01, `I_irq[0]` rises before edge k -> `PENDING` = 0x01 at k+2, `O_interrupt` = 1 after k+3, `VECTOR` = 0x00. Write 0x01 to reg 0 at w -> `O_interrupt` = 0 after w+1.
- **Priority and masking**: `ENABLE` = 0x0C, pulse `I_irq[1]` and `I_irq[3]` (3 cycles each) -> `PENDING` = 0x0A, `ACTIVE` = 0x08, `VECTOR` = 0x03. Write `ENABLE` = 0x0E -> `VECTOR` = 0x01.
- **Clear/edge collision**: `PENDING[2]` = 1; arrange a new edge on `I_irq[2]` to be detected in the same cycle as a write of 0x04 to reg 0 -> `PENDING[2]` stays 1 and `O_interrupt` stays high.
- **Software trigger and held level**:
  - Write 0x02 to reg 2 with `ENABLE` = 0x02 -> `PENDING` = 0x02, `O_interrupt` = 1. Clear it.
  - Hold `I_irq[0]` high for 50 cycles and clear `PENDING[0]` once -> it does not re-pend until the line falls and rises again.
- **Reset mid-operation and width**:
  - With `NUM_IRQ` = 2, `PENDING` = 0x03, `O_interrupt` = 1, assert `I_reset` asynchronously between edges -> `O_interrupt` = 0 immediately.
  - After release, write 0xFF to reg 1 -> reads back 0x03.
